// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder.
// The requester drives start and the operands; the adder returns status and the registered sum.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;

    modport master (
        output start, A, B, Cin,
        input  busy, done, S, Cout
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, S, Cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: computes A + B + Cin LSB first through a single full-adder cell,
// taking WIDTH cycles in SHIFT plus one DONE cycle per operation.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  s_sh;
    logic [WIDTH-1:0]  s_q;
    logic              c_q;
    logic              cout_q;
    logic              busy_q;
    logic              done_q;
    logic [CntW-1:0]   cnt_q;
    logic              sum_bit;
    logic              carry_bit;

    // Full-adder cell on the current LSBs and the recirculated carry.
    always_comb begin
        sum_bit   = a_sh[0] ^ b_sh[0] ^ c_q;
        carry_bit = (a_sh[0] & b_sh[0]) | (a_sh[0] & c_q) | (b_sh[0] & c_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh    <= '0;
            b_sh    <= '0;
            s_sh    <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh    <= bus.A;
                        b_sh    <= bus.B;
                        c_q     <= bus.Cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    s_sh  <= {sum_bit, s_sh[WIDTH-1:1]};
                    c_q   <= carry_bit;
                    cnt_q <= cnt_q + CntW'(1);
                    // Final bit: publish the result on the same edge that enters DONE.
                    if (cnt_q == LastBit) begin
                        s_q     <= {sum_bit, s_sh[WIDTH-1:1]};
                        cout_q  <= carry_bit;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed WIDTH=8 cases plus an exhaustive
// back-to-back WIDTH=4 sweep; a monitor per instance pops expected results on done.
module tb_serial_adder;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] q8[$];
    logic [4:0] q4[$];
    int done_cnt8 = 0;
    int cyc4      = 0;
    int last4     = -1;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(4)) bus4 ();

    serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor for the WIDTH=8 instance.
    always @(posedge clk) begin
        logic [8:0] exp8;
        #1;
        if (bus8.done) begin
            done_cnt8++;
            check("busy_with_done8", {31'd0, bus8.busy}, 32'd0);
            if (q8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done8: got S=0x%0h Cout=%0d, expected no done",
                         bus8.S, bus8.Cout);
            end else begin
                exp8 = q8.pop_front();
                check("sum8", {23'd0, bus8.Cout, bus8.S}, {23'd0, exp8});
            end
        end
    end

    // Monitor for the WIDTH=4 instance, also checking the done-to-done spacing.
    always @(posedge clk) begin
        logic [4:0] exp4;
        #1;
        cyc4++;
        if (bus4.done) begin
            if (q4.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done4: got S=0x%0h Cout=%0d, expected no done",
                         bus4.S, bus4.Cout);
            end else begin
                exp4 = q4.pop_front();
                check("sum4", {27'd0, bus4.Cout, bus4.S}, {27'd0, exp4});
            end
            if (last4 >= 0) check("interval4", cyc4 - last4, 32'd6);
            last4 = cyc4;
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [8:0] exp);
        int busy_cnt;
        int done_idx;
        @(negedge clk);
        q8.push_back(exp);
        bus8.A     = a;
        bus8.B     = b;
        bus8.Cin   = cin;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        busy_cnt = 0;
        done_idx = -1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus8.busy) busy_cnt++;
            if (bus8.done) begin
                done_idx = k;
                break;
            end
        end
        check("latency8", done_idx, 32'd8);
        check("busy_cycles8", busy_cnt, 32'd8);
        @(posedge clk);
        #1;
        check("idle_after8", {30'd0, bus8.busy, bus8.done}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int t;
        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.A     = '0;
        bus8.B     = '0;
        bus8.Cin   = 1'b0;
        bus4.start = 1'b0;
        bus4.A     = '0;
        bus4.B     = '0;
        bus4.Cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset8", {21'd0, bus8.busy, bus8.done, bus8.Cout, bus8.S}, 32'd0);
        check("reset4", {25'd0, bus4.busy, bus4.done, bus4.Cout, bus4.S}, 32'd0);
        rst_n = 1'b1;

        run8(8'h3C, 8'h5A, 1'b0, 9'h096);
        run8(8'hFF, 8'h01, 1'b0, 9'h100);
        run8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        run8(8'h00, 8'h00, 1'b0, 9'h000);

        // Start pulses during SHIFT and DONE must be ignored; operands change after E0.
        snap = done_cnt8;
        @(negedge clk);
        q8.push_back(9'h030);
        bus8.A     = 8'h10;
        bus8.B     = 8'h20;
        bus8.Cin   = 1'b0;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.A     = 8'hAA;
        bus8.B     = 8'h55;
        bus8.Cin   = 1'b1;
        repeat (3) @(negedge clk);
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        t = 0;
        while (!bus8.done && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("busy_start_done_seen", {31'd0, bus8.done}, 32'd1);
        @(negedge clk);
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (12) @(negedge clk);
        check("busy_start_one_done", done_cnt8 - snap, 32'd1);
        check("busy_start_idle", {31'd0, bus8.busy}, 32'd0);

        // Reset in the middle of SHIFT aborts and clears the result.
        snap = done_cnt8;
        @(negedge clk);
        bus8.A     = 8'h7F;
        bus8.B     = 8'h01;
        bus8.Cin   = 1'b0;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midop_reset", {21'd0, bus8.busy, bus8.done, bus8.Cout, bus8.S}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midop_no_done", done_cnt8 - snap, 32'd0);
        run8(8'h7F, 8'h01, 1'b0, 9'h080);

        // Exhaustive WIDTH=4 sweep with start held high for back-to-back operation.
        @(negedge clk);
        bus4.start = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    bus4.A   = 4'(a);
                    bus4.B   = 4'(b);
                    bus4.Cin = c[0];
                    q4.push_back(5'(a + b + c));
                    t = 0;
                    while (bus4.busy && t < 20) begin
                        @(posedge clk);
                        #1;
                        t++;
                    end
                    t = 0;
                    while (!bus4.busy && t < 20) begin
                        @(posedge clk);
                        #1;
                        t++;
                    end
                    if (!bus4.busy) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL accept4_timeout: got busy=0, expected busy=1 (a=%0d b=%0d c=%0d)",
                                 a, b, c);
                    end
                end
            end
        end
        bus4.start = 1'b0;

        t = 0;
        while ((q4.size() != 0 || q8.size() != 0) && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) @(negedge clk);
        check("drain4", q4.size(), 32'd0);
        check("drain8", q8.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
